// File: rtl/wb_dual_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant FSM encoding,
// master index constants and grant-vector helpers.
package wb_dual_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_M0 = 2'd1,
    ARB_GNT_M1 = 2'd2
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  // One-hot {m1,m0} grant vector for a master index.
  function automatic logic [1:0] grant_onehot(input logic idx);
    return (idx == MST_M1) ? 2'b10 : 2'b01;
  endfunction

  function automatic arb_state_e grant_state(input logic idx);
    return (idx == MST_M1) ? ARB_GNT_M1 : ARB_GNT_M0;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-response watchdog: counts stalled wait cycles of the granted master
// and raises a single-cycle fire pulse when the limit is reached.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic resp,
  input  logic clear,
  output logic fire
);

  localparam bit               ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;

  assign fire = ENABLED && active && (wd_cnt == LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (!ENABLED || clear || fire || resp) begin
      wd_cnt <= '0;
    end else if (active) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Shares one Wishbone slave between the data master (m0) and the instruction
// master (m1): registered round-robin grant, cycle lock, response watchdog.
module wb_dual_master_arbiter
  import wb_dual_master_arbiter_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int SW             = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic          clock,
  input  logic          reset,
  // master 0 (data bus)
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  // master 1 (instruction bus)
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  // shared slave
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  output logic [SW-1:0] s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  // status
  output logic [1:0]    out_Grant,
  output logic          out_Timeout
);

  arb_state_e state;
  logic       last_gnt;
  logic [1:0] grant;

  logic gnt_cyc;
  logic gnt_stb;
  logic wd_fire;

  // Grant FSM; the grant vector is registered alongside the state so the
  // slave-side muxes are driven straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      last_gnt <= MST_M1;
      grant    <= 2'b00;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state    <= grant_state(~last_gnt);
            grant    <= grant_onehot(~last_gnt);
            last_gnt <= ~last_gnt;
          end else if (m0_cyc_i) begin
            state    <= ARB_GNT_M0;
            grant    <= grant_onehot(MST_M0);
            last_gnt <= MST_M0;
          end else if (m1_cyc_i) begin
            state    <= ARB_GNT_M1;
            grant    <= grant_onehot(MST_M1);
            last_gnt <= MST_M1;
          end
        end
        ARB_GNT_M0: begin
          if (!m0_cyc_i) begin
            if (m1_cyc_i) begin
              state    <= ARB_GNT_M1;
              grant    <= grant_onehot(MST_M1);
              last_gnt <= MST_M1;
            end else begin
              state <= ARB_IDLE;
              grant <= 2'b00;
            end
          end
        end
        ARB_GNT_M1: begin
          if (!m1_cyc_i) begin
            if (m0_cyc_i) begin
              state    <= ARB_GNT_M0;
              grant    <= grant_onehot(MST_M0);
              last_gnt <= MST_M0;
            end else begin
              state <= ARB_IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else leaves a signal unassigned and no latch is inferred.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    gnt_cyc  = 1'b0;
    gnt_stb  = 1'b0;
    if (grant[0]) begin
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      gnt_cyc  = m0_cyc_i;
      gnt_stb  = m0_stb_i;
    end else if (grant[1]) begin
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      gnt_cyc  = m1_cyc_i;
      gnt_stb  = m1_stb_i;
    end
  end

  // Clearing on a dropped cyc covers both IDLE and every grant hand-over.
  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .active(gnt_cyc & gnt_stb),
    .resp  (s_ack_i | s_err_i | s_rty_i),
    .clear (~gnt_cyc),
    .fire  (wd_fire)
  );

  assign s_cyc_o = gnt_cyc & ~wd_fire;
  assign s_stb_o = gnt_stb & ~wd_fire;

  // A response colliding with a watchdog fire is dropped in favour of err.
  assign m0_ack_o = grant[0] & s_ack_i & ~wd_fire;
  assign m0_rty_o = grant[0] & s_rty_i & ~wd_fire;
  assign m0_err_o = grant[0] & (s_err_i | wd_fire);
  assign m1_ack_o = grant[1] & s_ack_i & ~wd_fire;
  assign m1_rty_o = grant[1] & s_rty_i & ~wd_fire;
  assign m1_err_o = grant[1] & (s_err_i | wd_fire);

  assign m0_data_o   = s_data_i;
  assign m1_data_o   = s_data_i;
  assign out_Grant   = grant;
  assign out_Timeout = wd_fire;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: one instance with a 4-cycle
// watchdog and one with the watchdog disabled, driven from shared stimulus.
module tb_wb_dual_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic          m0_we_i, m0_cyc_i, m0_stb_i;
  logic          m1_we_i, m1_cyc_i, m1_stb_i;
  logic [DW-1:0] s_data_i;
  logic          s_ack_i, s_err_i, s_rty_i;

  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]    out_Grant;
  logic          out_Timeout;

  logic [DW-1:0] nw_m0_data_o, nw_m1_data_o;
  logic          nw_m0_ack_o, nw_m0_err_o, nw_m0_rty_o, nw_m1_ack_o, nw_m1_err_o, nw_m1_rty_o;
  logic [AW-1:0] nw_s_addr_o;
  logic [DW-1:0] nw_s_data_o;
  logic [SW-1:0] nw_s_sel_o;
  logic          nw_s_we_o, nw_s_cyc_o, nw_s_stb_o;
  logic [1:0]    nw_out_Grant;
  logic          nw_out_Timeout;

  int n_total = 0;
  int n_pass  = 0;

  wb_dual_master_arbiter #(.DW(DW), .AW(AW), .SW(SW), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .out_Grant(out_Grant), .out_Timeout(out_Timeout)
  );

  wb_dual_master_arbiter #(.DW(DW), .AW(AW), .SW(SW), .TIMEOUT_CYCLES(0), .CNT_W(8)) dut_nowd (
    .clock(clock), .reset(reset),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_data_o(nw_m0_data_o), .m0_ack_o(nw_m0_ack_o),
    .m0_err_o(nw_m0_err_o), .m0_rty_o(nw_m0_rty_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_data_o(nw_m1_data_o), .m1_ack_o(nw_m1_ack_o),
    .m1_err_o(nw_m1_err_o), .m1_rty_o(nw_m1_rty_o),
    .s_addr_o(nw_s_addr_o), .s_data_o(nw_s_data_o), .s_sel_o(nw_s_sel_o), .s_we_o(nw_s_we_o),
    .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .out_Grant(nw_out_Grant), .out_Timeout(nw_out_Timeout)
  );

  task automatic idle_inputs();
    m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_data_i  = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic m0_req(input logic [AW-1:0] addr, input logic on);
    m0_addr_i = addr; m0_sel_i = 4'hF; m0_cyc_i = on; m0_stb_i = on;
  endtask

  task automatic m1_req(input logic [AW-1:0] addr, input logic on);
    m1_addr_i = addr; m1_sel_i = 4'hF; m1_cyc_i = on; m1_stb_i = on;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    m0_req(32'h0000_0010, 1'b1);
    m1_req(32'h0000_0020, 1'b1);
    s_ack_i  = 1'b1;
    s_data_i = 32'hDEAD_BEEF;
    @(negedge clock);
    @(negedge clock);
    #1;
    n_total++;
    if ({out_Grant, out_Timeout, s_cyc_o, s_stb_o} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {out_Grant, out_Timeout, s_cyc_o, s_stb_o});
    else n_pass++;
    n_total++;
    if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) $display("FAIL reset_resp: got %b want 000000", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o});
    else n_pass++;
    n_total++;
    if (s_addr_o !== 32'h0) $display("FAIL reset_s_addr: got %h want 00000000", s_addr_o);
    else n_pass++;
    n_total++;
    if (m0_data_o !== 32'hDEAD_BEEF || m1_data_o !== 32'hDEAD_BEEF) $display("FAIL reset_data_bcast: got %h/%h want deadbeef", m0_data_o, m1_data_o);
    else n_pass++;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clock);
    m0_req(32'h0000_0100, 1'b1);
    #1;
    n_total++;
    if (out_Grant !== 2'b00) $display("FAIL t1_grant_before: got %b want 00", out_Grant);
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b01 || s_addr_o !== 32'h100 || s_stb_o !== 1'b1) $display("FAIL t1_grant: got %b/%h/%b want 01/00000100/1", out_Grant, s_addr_o, s_stb_o);
    else n_pass++;
    @(negedge clock);
    @(negedge clock);
    s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
    #1;
    n_total++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_data_o !== 32'h1234_5678) $display("FAIL t1_ack: got %b/%h want 10/12345678", {m0_ack_o, m1_ack_o}, m0_data_o);
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b0;
    m0_req(32'h0000_0100, 1'b0);
    #1;
    n_total++;
    if (s_cyc_o !== 1'b0) $display("FAIL t1_release_cyc: got %b want 0", s_cyc_o);
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b00) $display("FAIL t1_idle: got %b want 00", out_Grant);
    else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    m0_req(32'h0000_0200, 1'b1);
    m1_req(32'h0000_0300, 1'b1);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b01 || s_addr_o !== 32'h200) $display("FAIL t2_first_tie: got %b/%h want 01/00000200", out_Grant, s_addr_o);
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b1;
    #1;
    n_total++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) $display("FAIL t2_ack_route: got %b want 10", {m0_ack_o, m1_ack_o});
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b0;
    m0_req(32'h0000_0200, 1'b0);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b10 || s_addr_o !== 32'h300) $display("FAIL t2_handover: got %b/%h want 10/00000300", out_Grant, s_addr_o);
    else n_pass++;
    m1_req(32'h0000_0300, 1'b0);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b00) $display("FAIL t2_idle: got %b want 00", out_Grant);
    else n_pass++;
    m0_req(32'h0000_0200, 1'b1);
    m1_req(32'h0000_0300, 1'b1);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b01) $display("FAIL t2_tie_b: got %b want 01", out_Grant);
    else n_pass++;
    m0_req(32'h0000_0200, 1'b0);
    m1_req(32'h0000_0300, 1'b0);
    @(negedge clock);
    m0_req(32'h0000_0200, 1'b1);
    m1_req(32'h0000_0300, 1'b1);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b10) $display("FAIL t2_tie_c: got %b want 10", out_Grant);
    else n_pass++;
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_locked_burst();
    m1_req(32'h0000_1000, 1'b1);
    m1_we_i = 1'b1; m1_data_i = 32'hCAFE_0001;
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b10 || s_we_o !== 1'b1 || s_data_o !== 32'hCAFE_0001) $display("FAIL t3_m1_grant: got %b/%b/%h want 10/1/cafe0001", out_Grant, s_we_o, s_data_o);
    else n_pass++;
    m0_req(32'h0000_2000, 1'b1);
    for (int beat = 0; beat < 4; beat++) begin
      @(negedge clock);
      s_ack_i = 1'b1;
      #1;
      n_total++;
      if ({out_Grant, m0_ack_o, m1_ack_o} !== 4'b1001) $display("FAIL t3_burst_beat%0d: got %b want 1001", beat, {out_Grant, m0_ack_o, m1_ack_o});
      else n_pass++;
    end
    @(negedge clock);
    s_ack_i = 1'b0;
    m1_req(32'h0000_1000, 1'b0);
    m1_we_i = 1'b0;
    #1;
    n_total++;
    if ({out_Grant, m0_ack_o} !== 3'b100) $display("FAIL t3_m1_release: got %b want 100", {out_Grant, m0_ack_o});
    else n_pass++;
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b01 || s_addr_o !== 32'h2000) $display("FAIL t3_m0_after: got %b/%h want 01/00002000", out_Grant, s_addr_o);
    else n_pass++;
    m0_req(32'h0000_2000, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_watchdog();
    m0_req(32'h0000_0400, 1'b1);
    for (int w = 1; w <= 4; w++) begin
      @(negedge clock); #1;
      n_total++;
      if ({out_Timeout, m0_err_o, s_stb_o} !== 3'b001) $display("FAIL t4_wait%0d: got %b want 001", w, {out_Timeout, m0_err_o, s_stb_o});
      else n_pass++;
    end
    @(negedge clock);
    s_ack_i = 1'b1;
    #1;
    n_total++;
    if ({out_Timeout, m0_err_o, m0_ack_o, s_stb_o, s_cyc_o, m1_err_o} !== 6'b110000) $display("FAIL t4_fire: got %b want 110000", {out_Timeout, m0_err_o, m0_ack_o, s_stb_o, s_cyc_o, m1_err_o});
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b0;
    m0_req(32'h0000_0400, 1'b0);
    #1;
    n_total++;
    if ({out_Timeout, m0_err_o} !== 2'b00) $display("FAIL t4_pulse_end: got %b want 00", {out_Timeout, m0_err_o});
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    m1_req(32'h0000_0500, 1'b1);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b10) $display("FAIL t5_m1_grant: got %b want 10", out_Grant);
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b1;
    reset   = 1'b1;
    #1;
    n_total++;
    if ({out_Grant, s_cyc_o, s_stb_o, m1_ack_o} !== 5'b0 || s_addr_o !== 32'h0) $display("FAIL t5_async_reset: got %b/%h want 00000/00000000", {out_Grant, s_cyc_o, s_stb_o, m1_ack_o}, s_addr_o);
    else n_pass++;
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    m0_req(32'h0000_0600, 1'b1);
    m1_req(32'h0000_0700, 1'b1);
    @(negedge clock); #1;
    n_total++;
    if (out_Grant !== 2'b01) $display("FAIL t5_tie_after_reset: got %b want 01", out_Grant);
    else n_pass++;
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_no_watchdog();
    int stall_bad;
    stall_bad = 0;
    m0_req(32'h0000_0800, 1'b1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clock); #1;
      if (nw_m0_err_o !== 1'b0 || nw_out_Timeout !== 1'b0 || nw_s_stb_o !== 1'b1) stall_bad++;
    end
    n_total++;
    if (stall_bad !== 0) $display("FAIL t6_stall: got %0d bad cycles want 0", stall_bad);
    else n_pass++;
    @(negedge clock);
    s_ack_i = 1'b1; s_data_i = 32'h0BAD_F00D;
    #1;
    n_total++;
    if ({nw_out_Grant, nw_m0_ack_o, nw_m0_err_o} !== 4'b0110 || nw_m0_data_o !== 32'h0BAD_F00D) $display("FAIL t6_late_ack: got %b/%h want 0110/0badf00d", {nw_out_Grant, nw_m0_ack_o, nw_m0_err_o}, nw_m0_data_o);
    else n_pass++;
    idle_inputs();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_locked_burst();
    test_watchdog();
    test_reset_mid();
    test_no_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
